// File: rtl/memaccess_ctrl_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | memaccess_ctrl_pkg : opcodes, bus encodings and FSM states for MemAccess |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package memaccess_ctrl_pkg;

   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_STI = 4'b1011;

   typedef enum logic [1:0] {
      MS_RD   = 2'd0,
      MS_IND  = 2'd1,
      MS_WR   = 2'd2,
      MS_IDLE = 2'd3
   } mem_state_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_IND  = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/memaccess_wdog.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | memaccess_wdog : per-access wait counter, expires on the last allowed    |
// | wait cycle.                                              rev 1.0         |
// +-------------------------------------------------------------------------+
module memaccess_wdog #(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] count;

   // count is 0 in the first wait cycle, so expiry on LAST gives TIMEOUT cycles
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/memaccess_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | memaccess_ctrl : LC3 MemAccess sequencer (direct and indirect accesses)  |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module memaccess_ctrl
   import memaccess_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        exec_valid,
   input  logic [3:0]  opcode,
   input  logic [15:0] addr_in,
   input  logic [15:0] data_in,
   input  logic        complete_data,
   input  logic [15:0] data_dout,
   output logic [1:0]  mem_state,
   output logic        m_control,
   output logic [15:0] m_addr,
   output logic [15:0] m_data,
   output logic        stall,
   output logic        mem_done,
   output logic [15:0] load_data,
   output logic        timeout_err
);

   fsm_state_t  state;
   logic        ind_load;
   logic [15:0] store_data;
   logic        waiting;
   logic        wd_clear;
   logic        expired;

   assign waiting  = (state == ST_IND) || (state == ST_RD) || (state == ST_WR);
   // a completion always leaves the current wait state, so it restarts the count
   assign wd_clear = !waiting || complete_data;

   memaccess_wdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_wdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (waiting),
      .expired (expired)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         ind_load    <= 1'b0;
         store_data  <= '0;
         mem_state   <= MS_IDLE;
         m_control   <= 1'b0;
         m_addr      <= '0;
         m_data      <= '0;
         stall       <= 1'b0;
         mem_done    <= 1'b0;
         load_data   <= '0;
         timeout_err <= 1'b0;
      end else begin
         mem_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (exec_valid) begin
                  case (opcode)
                     OP_LD, OP_LDR: begin
                        state     <= ST_RD;
                        mem_state <= MS_RD;
                        m_control <= 1'b0;
                        m_addr    <= addr_in;
                        stall     <= 1'b1;
                     end
                     OP_ST, OP_STR: begin
                        state     <= ST_WR;
                        mem_state <= MS_WR;
                        m_control <= 1'b0;
                        m_addr    <= addr_in;
                        m_data    <= data_in;
                        stall     <= 1'b1;
                     end
                     OP_LDI, OP_STI: begin
                        state      <= ST_IND;
                        mem_state  <= MS_IND;
                        m_control  <= 1'b0;
                        m_addr     <= addr_in;
                        ind_load   <= (opcode == OP_LDI);
                        store_data <= data_in;
                        stall      <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end

            ST_IND: begin
               if (complete_data) begin
                  // m_addr itself holds the captured pointer from here on
                  m_control <= 1'b1;
                  m_addr    <= data_dout;
                  if (ind_load) begin
                     state     <= ST_RD;
                     mem_state <= MS_RD;
                  end else begin
                     state     <= ST_WR;
                     mem_state <= MS_WR;
                     m_data    <= store_data;
                  end
               end else if (expired) begin
                  timeout_err <= 1'b1;
                  state       <= ST_DONE;
                  mem_state   <= MS_IDLE;
                  m_control   <= 1'b0;
                  mem_done    <= 1'b1;
               end
            end

            ST_RD, ST_WR: begin
               if (complete_data || expired) begin
                  if (complete_data) begin
                     if (state == ST_RD) begin
                        load_data <= data_dout;
                     end
                  end else begin
                     timeout_err <= 1'b1;
                  end
                  state     <= ST_DONE;
                  mem_state <= MS_IDLE;
                  m_control <= 1'b0;
                  mem_done  <= 1'b1;
               end
            end

            ST_DONE: begin
               state     <= ST_IDLE;
               mem_state <= MS_IDLE;
               stall     <= 1'b0;
            end

            default: begin
               state     <= ST_IDLE;
               mem_state <= MS_IDLE;
               m_control <= 1'b0;
               stall     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memaccess_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_memaccess_ctrl : transaction-level reference bench for memaccess_ctrl |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_memaccess_ctrl;

   localparam int TIMEOUT = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        exec_valid = 1'b0;
   logic [3:0]  opcode = '0;
   logic [15:0] addr_in = '0;
   logic [15:0] data_in = '0;
   logic        complete_data = 1'b0;
   logic [15:0] data_dout = '0;
   logic [1:0]  mem_state;
   logic        m_control;
   logic [15:0] m_addr;
   logic [15:0] m_data;
   logic        stall;
   logic        mem_done;
   logic [15:0] load_data;
   logic        timeout_err;

   int          checks = 0;
   int          failures = 0;
   logic        exp_err = 1'b0;
   logic [15:0] exp_load = '0;
   logic        force_busy = 1'b0;
   logic [3:0]  mem_ops [6] = '{4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011};

   memaccess_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
      .clock         (clock),
      .reset         (reset),
      .exec_valid    (exec_valid),
      .opcode        (opcode),
      .addr_in       (addr_in),
      .data_in       (data_in),
      .complete_data (complete_data),
      .data_dout     (data_dout),
      .mem_state     (mem_state),
      .m_control     (m_control),
      .m_addr        (m_addr),
      .m_data        (m_data),
      .stall         (stall),
      .mem_done      (mem_done),
      .load_data     (load_data),
      .timeout_err   (timeout_err)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [3:0] rand_mem_op();
      return mem_ops[$urandom_range(5)];
   endfunction

   task automatic check_reset_vals();
      check_eq("rst_mem_state", 32'(mem_state), 32'd3);
      check_eq("rst_m_control", 32'(m_control), 32'd0);
      check_eq("rst_m_addr", 32'(m_addr), 32'd0);
      check_eq("rst_m_data", 32'(m_data), 32'd0);
      check_eq("rst_stall", 32'(stall), 32'd0);
      check_eq("rst_mem_done", 32'(mem_done), 32'd0);
      check_eq("rst_load_data", 32'(load_data), 32'd0);
      check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
   endtask

   // One access of up to TIMEOUT cycles; memory answers in wait cycle 'lat'.
   task automatic wait_phase(input logic [1:0] ms, input logic ctl, input logic [15:0] adr,
                             input logic [15:0] wdat, input int lat, input logic [15:0] rval,
                             output logic timed);
      timed = 1'b0;
      for (int w = 0; w < TIMEOUT; w++) begin
         check_eq("mem_state", 32'(mem_state), 32'(ms));
         check_eq("m_control", 32'(m_control), 32'(ctl));
         check_eq("m_addr", 32'(m_addr), 32'(adr));
         check_eq("stall", 32'(stall), 32'd1);
         check_eq("mem_done_busy", 32'(mem_done), 32'd0);
         check_eq("timeout_err", 32'(timeout_err), 32'(exp_err));
         if (ms == 2'd2) check_eq("m_data", 32'(m_data), 32'(wdat));
         exec_valid    = force_busy | ($urandom_range(3) == 0);
         opcode        = rand_mem_op();
         addr_in       = 16'($urandom);
         data_in       = 16'($urandom);
         complete_data = (w == lat);
         data_dout     = (w == lat) ? rval : 16'($urandom);
         step();
         complete_data = 1'b0;
         exec_valid    = 1'b0;
         if (w == lat) return;
      end
      timed = 1'b1;
   endtask

   task automatic run_txn(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] data,
                          input logic [15:0] ptr, input logic [15:0] rval, input int lat1,
                          input int lat2);
      logic timed, ind, isload, mem;
      logic [1:0] final_ms;
      mem    = op inside {4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011};
      ind    = op inside {4'b1010, 4'b1011};
      isload = op inside {4'b0010, 4'b0110, 4'b1010};
      final_ms = isload ? 2'd0 : 2'd2;
      exec_valid = 1'b1;
      opcode     = op;
      addr_in    = addr;
      data_in    = data;
      step();
      exec_valid = 1'b0;
      if (!mem) begin
         check_eq("nonmem_stall", 32'(stall), 32'd0);
         check_eq("nonmem_state", 32'(mem_state), 32'd3);
         check_eq("nonmem_done", 32'(mem_done), 32'd0);
         step();
         check_eq("nonmem_stall2", 32'(stall), 32'd0);
         return;
      end
      if (ind) begin
         wait_phase(2'd1, 1'b0, addr, data, lat1, ptr, timed);
         if (!timed) wait_phase(final_ms, 1'b1, ptr, data, lat2, rval, timed);
      end else begin
         wait_phase(final_ms, 1'b0, addr, data, lat1, rval, timed);
      end
      if (timed) exp_err = 1'b1;
      else if (isload) exp_load = rval;
      check_eq("done_pulse", 32'(mem_done), 32'd1);
      check_eq("done_state", 32'(mem_state), 32'd3);
      check_eq("done_stall", 32'(stall), 32'd1);
      check_eq("done_err", 32'(timeout_err), 32'(exp_err));
      check_eq("done_load", 32'(load_data), 32'(exp_load));
      exec_valid    = ($urandom_range(1) == 0);
      opcode        = rand_mem_op();
      complete_data = ($urandom_range(1) == 0);
      data_dout     = 16'($urandom);
      step();
      exec_valid    = 1'b0;
      complete_data = 1'b0;
      check_eq("idle_done", 32'(mem_done), 32'd0);
      check_eq("idle_stall", 32'(stall), 32'd0);
      check_eq("idle_state", 32'(mem_state), 32'd3);
      check_eq("idle_load", 32'(load_data), 32'(exp_load));
      check_eq("idle_err", 32'(timeout_err), 32'(exp_err));
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check_eq("quiet_done", 32'(mem_done), 32'd0);
         check_eq("quiet_stall", 32'(stall), 32'd0);
      end
   endtask

   initial begin
      int lat_a, lat_b;
      step();
      step();
      check_reset_vals();
      reset = 1'b0;
      step();
      check_reset_vals();

      run_txn(4'b0010, 16'h3000, 16'h0000, 16'h0000, 16'hBEEF, 1, 0);
      run_txn(4'b0111, 16'h4010, 16'h1234, 16'h0000, 16'h0000, 0, 0);
      run_txn(4'b1010, 16'h3002, 16'h0000, 16'h5000, 16'h00AA, 0, 0);
      // completion on the very last allowed wait cycle is not a timeout
      run_txn(4'b0110, 16'h2222, 16'h0000, 16'h0000, 16'h7777, TIMEOUT - 1, 0);
      run_txn(4'b1011, 16'h1111, 16'h9999, 16'h6000, 16'h0000, 2, TIMEOUT - 1);

      run_txn(4'b0001, 16'h0123, 16'h4567, 16'h0000, 16'h0000, 0, 0);
      force_busy = 1'b1;
      run_txn(4'b0010, 16'h3100, 16'h0000, 16'h0000, 16'h5A5A, 3, 0);
      force_busy = 1'b0;
      idle_check(3);

      run_txn(4'b1011, 16'h3004, 16'hCAFE, 16'h0000, 16'h0000, 1000, 0);
      run_txn(4'b0010, 16'h3006, 16'h0000, 16'h0000, 16'h1357, 0, 0);

      // reset while an LDI waits on its pointer
      exec_valid = 1'b1;
      opcode     = 4'b1010;
      addr_in    = 16'h3008;
      step();
      exec_valid = 1'b0;
      check_eq("pre_rst_state", 32'(mem_state), 32'd1);
      reset = 1'b1;
      step();
      check_reset_vals();
      reset    = 1'b0;
      exp_err  = 1'b0;
      exp_load = '0;
      step();
      check_reset_vals();
      run_txn(4'b0010, 16'h300A, 16'h0000, 16'h0000, 16'h2468, 0, 0);

      for (int t = 0; t < 250; t++) begin
         lat_a = ($urandom_range(24) == 0) ? TIMEOUT - 2 + int'($urandom_range(3)) : int'($urandom_range(3));
         lat_b = ($urandom_range(24) == 0) ? TIMEOUT - 2 + int'($urandom_range(3)) : int'($urandom_range(3));
         run_txn(($urandom_range(7) == 0) ? 4'($urandom) : rand_mem_op(), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), lat_a, lat_b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
